// File: rtl/fetch_if.sv
// fetch_if: control-FSM and instruction-memory signals of the fetch stage.
// The master modport is the fetch unit's side of the bundle.
// The slave modport is the environment's side: control FSM and instruction memory.
// With FETCH_HALT_STOP_EN defined, the bundle also carries the halted flag.
interface fetch_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          fetch_go;
    logic          br_load;
    logic          br_rel;
    logic [AW-1:0] br_addr;
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_rdy;
    logic [DW-1:0] im_data;
    logic [DW-1:0] ir;
    logic [3:0]    opcode;
    logic [3:0]    mm;
    logic [AW-1:0] pc;
    logic          ir_valid;
    logic          busy;
    logic          fetch_err;
`ifdef FETCH_HALT_STOP_EN
    logic          halted;

    modport master (
        input  fetch_go, br_load, br_rel, br_addr, im_rdy, im_data,
        output im_req, im_addr, ir, opcode, mm, pc, ir_valid, busy, fetch_err, halted
    );
    modport slave (
        output fetch_go, br_load, br_rel, br_addr, im_rdy, im_data,
        input  im_req, im_addr, ir, opcode, mm, pc, ir_valid, busy, fetch_err, halted
    );
`else
    modport master (
        input  fetch_go, br_load, br_rel, br_addr, im_rdy, im_data,
        output im_req, im_addr, ir, opcode, mm, pc, ir_valid, busy, fetch_err
    );
    modport slave (
        output fetch_go, br_load, br_rel, br_addr, im_rdy, im_data,
        input  im_req, im_addr, ir, opcode, mm, pc, ir_valid, busy, fetch_err
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the SISC control FSM.
// Owns PC and IR, reads instruction memory over a req/rdy handshake with a
// WAIT timeout, and applies absolute/relative branches. A branch that arrives
// while a fetch is in flight is held and applied in the next IDLE cycle.
// Optional macro FETCH_HALT_STOP_EN: fetching an HLT opcode (4'hF) halts the unit.
module fetch_unit #(
    parameter int            AW       = 16,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 15
) (
    input  logic     clk,
    input  logic     rst_f,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_LOAD} state_t;

    // Counter value on the last WAIT cycle that may still be waited out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q;
    logic          err_q;
    logic [7:0]    cnt_q;
    logic          pend_q;
    logic          pend_rel_q;
    logic [AW-1:0] pend_addr_q;
    logic          halt_now;
    logic [AW-1:0] br_tgt;
    logic [AW-1:0] pend_tgt;

`ifdef FETCH_HALT_STOP_EN
    logic halted_q;
    assign halt_now   = halted_q;
    assign bus.halted = halted_q;
`else
    assign halt_now = 1'b0;
`endif

    // Branch targets: relative offsets wrap modulo 2^AW.
    assign br_tgt   = bus.br_rel ? pc_q + bus.br_addr : bus.br_addr;
    assign pend_tgt = pend_rel_q ? pc_q + pend_addr_q : pend_addr_q;

    // Next-state decode of the fetch handshake.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.fetch_go && !halt_now) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (bus.im_rdy || cnt_q == TO_LAST) state_d = S_LOAD;
            S_LOAD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values, whatever the statement order.
        if (!rst_f) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: PC, IR, timeout counter, sticky error and pending branch.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_rel_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!halt_now) begin
                        if (bus.br_load) begin
                            pc_q   <= br_tgt;
                            pend_q <= 1'b0;
                        end else if (pend_q) begin
                            pc_q   <= pend_tgt;
                            pend_q <= 1'b0;
                        end
                    end
                end
                S_REQ: cnt_q <= '0;
                S_WAIT: begin
                    if (bus.im_rdy) begin
                        ir_q <= bus.im_data;
                    end else if (cnt_q == TO_LAST) begin
                        ir_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_LOAD: pc_q <= pc_q + AW'(1);
                default: ;
            endcase
            // Branches outside IDLE are held; the latest one wins.
            if (state_q != S_IDLE && bus.br_load) begin
                pend_q      <= 1'b1;
                pend_rel_q  <= bus.br_rel;
                pend_addr_q <= bus.br_addr;
            end
        end
    end

`ifdef FETCH_HALT_STOP_EN
    // Halt latch: set when an HLT word completes LOAD; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_f)                                             halted_q <= 1'b0;
        else if (state_q == S_LOAD && ir_q[DW-1 -: 4] == 4'hF) halted_q <= 1'b1;
    end
`endif

    assign bus.im_req    = (state_q == S_REQ) || (state_q == S_WAIT);
    assign bus.busy      = bus.im_req;
    assign bus.im_addr   = bus.im_req ? pc_q : '0;
    assign bus.ir_valid  = (state_q == S_LOAD);
    assign bus.ir        = ir_q;
    assign bus.opcode    = ir_q[DW-1 -: 4];
    assign bus.mm        = ir_q[DW-5 -: 4];
    assign bus.pc        = pc_q;
    assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Keeps the expected architectural
// state (PC, IR, error, request/valid) and compares the DUT every negedge,
// plus literal checks on latency, request length and key PC values.
module tb_fetch_unit;
    localparam int            AW       = 16;
    localparam int            DW       = 32;
    localparam int            TIMEOUT  = 15;
    localparam logic [AW-1:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst_f;
    always #5 clk = ~clk;

    fetch_if #(.AW(AW), .DW(DW)) bus();

    fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected state.
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir;
    logic          m_err, m_req, m_valid;
    bit            m_pend;
    logic          m_pend_rel;
    logic [AW-1:0] m_pend_addr;
    bit            m_halted;
    bit            chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",        bus.pc,        m_pc);
            check("ir",        bus.ir,        m_ir);
            check("opcode",    bus.opcode,    m_ir[DW-1 -: 4]);
            check("mm",        bus.mm,        m_ir[DW-5 -: 4]);
            check("fetch_err", bus.fetch_err, m_err);
            check("im_req",    bus.im_req,    m_req);
            check("busy",      bus.busy,      m_req);
            check("im_addr",   bus.im_addr,   m_req ? m_pc : 16'h0000);
            check("ir_valid",  bus.ir_valid,  m_valid);
`ifdef FETCH_HALT_STOP_EN
            check("halted",    bus.halted,    m_halted);
`endif
        end
    end

    // Observers for latency, request-run length and ir_valid pulse count.
    int cyc = 0, go_cyc = 0, last_lat = 0, req_run = 0, last_run = 0, valid_cnt = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.ir_valid) begin
            valid_cnt++;
            last_lat = cyc - go_cyc;
        end
        if (bus.im_req) req_run++;
        else if (req_run > 0) begin
            last_run = req_run;
            req_run  = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [DW-1:0] data;
        int            rdy_at;    // WAIT cycle (1-based) with im_rdy; 0 = never
        int            br_at;     // WAIT cycle with br_load; 0 = none
        logic          br_rel;
        logic [AW-1:0] br_addr;
        int            go_at;     // WAIT cycle with a stray fetch_go; 0 = none
        bit            pre_br;    // branch in the fetch_go cycle
        logic          pre_rel;
        logic [AW-1:0] pre_addr;
        bit            post_br;   // branch in the first IDLE cycle after LOAD
        logic          post_rel;
        logic [AW-1:0] post_addr;
    } fetch_opt_t;

    function automatic fetch_opt_t plain(input logic [DW-1:0] data, input int rdy_at);
        fetch_opt_t o;
        o = '{data: data, rdy_at: rdy_at, br_at: 0, br_rel: 1'b0, br_addr: '0, go_at: 0,
              pre_br: 0, pre_rel: 1'b0, pre_addr: '0, post_br: 0, post_rel: 1'b0, post_addr: '0};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        step();
        m_pc = RESET_PC; m_ir = '0; m_err = 0; m_req = 0; m_valid = 0;
        m_pend = 0; m_halted = 0;
        rst_f = 1'b1;
    endtask

    task automatic idle_branch(input logic rel, input logic [AW-1:0] a);
        bus.br_load = 1'b1; bus.br_rel = rel; bus.br_addr = a;
        step();
        m_pc   = rel ? m_pc + a : a;
        m_pend = 0;
        bus.br_load = 1'b0;
    endtask

    task automatic do_fetch(input fetch_opt_t o);
        bit done = 0;
        go_cyc = cyc;
        bus.fetch_go = 1'b1;
        if (o.pre_br) begin
            bus.br_load = 1'b1; bus.br_rel = o.pre_rel; bus.br_addr = o.pre_addr;
        end
        step();                                   // now in REQ
        if (o.pre_br) m_pc = o.pre_rel ? m_pc + o.pre_addr : o.pre_addr;
        m_req = 1;
        bus.fetch_go = 1'b0; bus.br_load = 1'b0;
        step();                                   // now in first WAIT cycle
        for (int k = 1; k <= TIMEOUT && !done; k++) begin
            bus.im_rdy   = (k == o.rdy_at);
            bus.im_data  = (k == o.rdy_at) ? o.data : 32'hDEAD_BEEF;
            bus.br_load  = (k == o.br_at);
            bus.br_rel   = o.br_rel;
            bus.br_addr  = o.br_addr;
            bus.fetch_go = (k == o.go_at);
            step();
            bus.im_rdy = 1'b0; bus.br_load = 1'b0; bus.fetch_go = 1'b0;
            if (k == o.br_at) begin
                m_pend = 1; m_pend_rel = o.br_rel; m_pend_addr = o.br_addr;
            end
            if (k == o.rdy_at) begin
                m_ir = o.data; done = 1;
            end else if (k == TIMEOUT) begin
                m_ir = '0; m_err = 1; done = 1;
            end
            if (done) begin
                m_req = 0; m_valid = 1;
            end
        end
        step();                                   // LOAD -> IDLE
        m_valid = 0;
        m_pc    = m_pc + 16'h0001;
`ifdef FETCH_HALT_STOP_EN
        if (m_ir[DW-1 -: 4] == 4'hF) m_halted = 1;
`endif
        if (o.post_br) begin
            idle_branch(o.post_rel, o.post_addr);
        end else if (m_pend) begin
            step();
            m_pc   = m_pend_rel ? m_pc + m_pend_addr : m_pend_addr;
            m_pend = 0;
        end
    endtask

    initial begin
        fetch_opt_t o;
        int v0;
        rst_f = 1'b0;
        bus.fetch_go = 1'b0; bus.br_load = 1'b0; bus.br_rel = 1'b0; bus.br_addr = '0;
        bus.im_rdy = 1'b0; bus.im_data = '0;

        // Reset state.
        do_reset();
        chk_en = 1;
        check("rst_pc",   bus.pc,        16'h0000);
        check("rst_ir",   bus.ir,        32'h0);
        check("rst_busy", bus.busy,      1'b0);
        check("rst_err",  bus.fetch_err, 1'b0);

        // Minimum-latency fetch.
        do_fetch(plain(32'h8123_0000, 1));
        check("t1_latency", 32'(last_lat), 32'd3);
        check("t1_opcode",  bus.opcode,    4'h8);
        check("t1_mm",      bus.mm,        4'h1);
        check("t1_pc",      bus.pc,        16'h0001);

        // Slow memory: rdy on the 5th WAIT cycle; stray fetch_go in WAIT is dropped.
        v0 = valid_cnt;
        o = plain(32'h1234_5678, 5);
        o.go_at = 2;
        do_fetch(o);
        step();
        check("t2_req_cycles", 32'(last_run),  32'd6);
        check("t2_one_load",   32'(valid_cnt), 32'(v0 + 1));
        check("t2_err",        bus.fetch_err,  1'b0);
        check("t2_ir",         bus.ir,         32'h1234_5678);
        check("t2_no_queue",   bus.busy,       1'b0);

        // im_rdy on the timeout cycle wins.
        do_fetch(plain(32'h2AB0_0000, TIMEOUT));
        check("t3_err",        bus.fetch_err, 1'b0);
        check("t3_ir",         bus.ir,        32'h2AB0_0000);
        check("t3_req_cycles", 32'(last_run), 32'd16);

        // Timeout.
        do_fetch(plain(32'h0, 0));
        check("t4_err",        bus.fetch_err, 1'b1);
        check("t4_ir",         bus.ir,        32'h0);
        check("t4_req_cycles", 32'(last_run), 32'd16);
        check("t4_pc",         bus.pc,        16'h0004);
        check("t4_idle",       bus.busy,      1'b0);

        // Relative branch in IDLE, then absolute branch held during WAIT.
        idle_branch(1'b0, 16'h0010);
        idle_branch(1'b1, 16'hFFFC);
        check("t5_rel_pc", bus.pc, 16'h000C);
        o = plain(32'h3000_0001, 2);
        o.br_at = 1; o.br_rel = 1'b0; o.br_addr = 16'h0040;
        do_fetch(o);
        check("t5_pend_pc", bus.pc, 16'h0040);

        // New IDLE branch overrides a pending one.
        o = plain(32'h4000_0000, 1);
        o.br_at = 1; o.br_rel = 1'b0; o.br_addr = 16'h1111;
        o.post_br = 1; o.post_rel = 1'b1; o.post_addr = 16'h0002;
        do_fetch(o);
        step(); step();
        check("t6_override_pc", bus.pc, 16'h0043);

        // Branch with fetch_go in the same cycle, then PC wrap.
        o = plain(32'h5A00_0000, 1);
        o.pre_br = 1; o.pre_rel = 1'b0; o.pre_addr = 16'hFFFF;
        do_fetch(o);
        check("t7_wrap_pc", bus.pc, 16'h0000);

        // Reset in mid-WAIT with im_rdy in the same cycle.
        idle_branch(1'b0, 16'h0077);
        go_cyc = cyc;
        bus.fetch_go = 1'b1;
        step();
        m_req = 1;
        bus.fetch_go = 1'b0;
        step();
        rst_f = 1'b0; bus.im_rdy = 1'b1; bus.im_data = 32'h9999_9999;
        v0 = valid_cnt;
        step();
        m_pc = RESET_PC; m_ir = '0; m_err = 0; m_req = 0; m_valid = 0; m_pend = 0; m_halted = 0;
        rst_f = 1'b1; bus.im_rdy = 1'b0;
        step(); step(); step();
        check("t8_ir",       bus.ir,          32'h0);
        check("t8_pc",       bus.pc,          16'h0000);
        check("t8_no_valid", 32'(valid_cnt),  32'(v0));
        check("t8_err",      bus.fetch_err,   1'b0);

`ifdef FETCH_HALT_STOP_EN
        // HLT stops further fetches and branches.
        do_fetch(plain(32'hF000_0000, 1));
        check("t9_halted", bus.halted, 1'b1);
        bus.fetch_go = 1'b1;
        step();
        bus.fetch_go = 1'b0;
        bus.br_load = 1'b1; bus.br_rel = 1'b0; bus.br_addr = 16'h0123;
        step();
        bus.br_load = 1'b0;
        step();
        check("t9_no_req", bus.im_req, 1'b0);
        check("t9_pc",     bus.pc,     16'h0001);
`endif

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the SISC control FSM.
- Owns the program counter (PC) and instruction register (IR); requests words from instruction memory over a req/rdy handshake.
- Supplies opcode and mm to the control FSM.
- Applies absolute and relative branch loads to the PC.

Parameters:
- AW, 16, PC / instruction-address width.
- DW, 32, instruction width; opcode = ir[DW-1:DW-4], mm = ir[DW-5:DW-8].
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum cycles spent in WAIT before the fetch is aborted (1..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_f  in  1  synchronous, active-low reset, sampled on posedge clk.
- fetch_go  in  1  single-cycle request from the control FSM to fetch the next instruction.
- br_load  in  1  single-cycle branch request.
- br_rel  in  1  1 = relative branch (PC + br_addr), 0 = absolute (PC = br_addr).
- br_addr  in  AW  branch target or offset; two's-complement when br_rel=1.
- im_req  out  1  instruction-memory read request.
- im_addr  out  AW  instruction-memory address.
- im_rdy  in  1  memory data valid this cycle.
- im_data  in  DW  instruction word.
- ir  out  DW  instruction register.
- opcode  out  4  ir[DW-1:DW-4].
- mm  out  4  ir[DW-5:DW-8].
- pc  out  AW  current PC.
- ir_valid  out  1  one-cycle pulse when a new IR value is loaded.
- busy  out  1  high in REQ and WAIT.
- fetch_err  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (rst_f=0 at posedge):
  - state=IDLE, pc=RESET_PC, ir=0, im_req=0, im_addr=0, ir_valid=0, busy=0, fetch_err=0.
  - Pending branch and timeout counter cleared.
  - Reset overrides all other inputs, including in mid-WAIT; an im_rdy arriving in the reset cycle is discarded.
- States: IDLE, REQ, WAIT, LOAD.
- IDLE:
  - fetch_go=1 -> REQ.
  - If a branch is applied in the same cycle (see branch rules), it updates the PC first; the fetch in REQ uses the new PC.
- REQ (1 cycle): im_req=1, im_addr=pc; -> WAIT.
- WAIT:
  - im_req stays 1, im_addr held.
  - im_rdy=1 -> capture im_data into ir, then -> LOAD.
  - Counter increments each WAIT cycle without im_rdy. When it reaches TIMEOUT, fetch_err<=1, ir<=0 (NOOP), -> LOAD.
  - Timeout and im_rdy in the same cycle: im_rdy wins; no error.
- LOAD (1 cycle):
  - ir_valid=1, im_req=0.
  - pc<=pc+1, modulo 2^AW (0xFFFF wraps to 0x0000).
  - -> IDLE.
- Minimum latency: fetch_go to ir_valid is 3 cycles with im_rdy=1 on the first WAIT cycle.
- fetch_go outside IDLE is ignored and not queued.
- Branch rules:
  - br_load in IDLE takes effect at that posedge: pc <= br_addr (abs) or pc + br_addr (rel, modulo 2^AW).
  - br_load in REQ, WAIT or LOAD is latched as a pending branch. It is applied in the first IDLE cycle, after LOAD's increment. A later br_load overwrites an earlier pending one.
  - A pending branch and a new IDLE br_load in the same cycle: the new br_load wins; pending is cleared.
- opcode and mm are continuous slices of ir; they change only when ir loads.

Optional Feature:
- Macro: FETCH_HALT_STOP_EN.
- Defined:
  - Loading an IR with opcode 4'hF (HLT) sets an internal halted flag in LOAD.
  - While halted: fetch_go and br_load are ignored, pc does not increment, im_req stays 0.
  - Only rst_f=0 clears halted.
  - An extra output port halted (1 bit, reset 0) exists.
- Undefined: HLT is fetched like any other opcode; no halted port or logic.

Test Plan:
- Reset, then fetch_go with im_rdy on the first WAIT cycle and im_data=32'h8123_0000 -> im_addr=0; ir_valid 3 cycles after fetch_go; opcode=8, mm=1, pc=1.
- Memory delays im_rdy by 5 cycles -> im_req held 6 cycles at the same im_addr; ir loads once; fetch_err=0.
- Never assert im_rdy, TIMEOUT=15 -> fetch_err=1 after 15 WAIT cycles; ir=0, pc incremented, state IDLE.
- pc=0x0010: br_load rel with br_addr=0xFFFC in IDLE -> pc=0x000C. Next, br_load abs 0x0040 during WAIT -> after LOAD, pc=0x0040 (not 0x000D).
- pc=0xFFFF, fetch completes -> pc=0x0000. Then assert rst_f=0 mid-WAIT together with im_rdy -> ir=0, ir_valid never pulses, pc=RESET_PC.
- With FETCH_HALT_STOP_EN: fetch im_data=32'hF000_0000 -> halted=1; a further fetch_go gives no im_req.
